// File: rtl/mmcm_lock_sequencer.sv
// MMCM bring-up sequencer: pulses the MMCM reset, waits for and qualifies LOCKED,
// then releases the system reset. Retries bounded lock timeouts and counts lock losses.
module mmcm_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4,
  parameter int RSTN_DELAY    = 16
) (
  input  logic       sysClk_i,
  input  logic       RESETn_i,
  input  logic       mmcmLocked_i,
  input  logic       restart_i,
  output logic       mmcmRst_o,
  output logic       pllReady_o,
  output logic       sysRstn_o,
  output logic       fail_o,
  output logic [3:0] retryCnt_o,
  output logic [7:0] lockLossCnt_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_RESET_HOLD = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK  = 3'd1;
  localparam logic [2:0] S_STABLE     = 3'd2;
  localparam logic [2:0] S_RUN        = 3'd3;
  localparam logic [2:0] S_FAIL       = 3'd4;

  localparam logic [31:0] RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TO_LAST     = 32'(LOCK_TIMEOUT - 1);
  localparam logic [31:0] STABLE_LAST = 32'(STABLE_CYCLES - 1);
  localparam logic [31:0] RSTN_LAST   = 32'(RSTN_DELAY - 1);
  localparam logic [3:0]  MAX_R       = 4'(MAX_RETRY);

  logic        lockMeta_q, lockSync_q;
  logic [2:0]  state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  loss_q, loss_d;
  logic        mmcmRst_q, mmcmRst_d;
  logic        pllReady_q, pllReady_d;
  logic        sysRstn_q, sysRstn_d;
  logic        fail_q, fail_d;
  logic        lossEvt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    lossEvt = (state_q == S_RUN) && !lockSync_q;
    // A lock loss is counted even when a restart request wins the transition.
    if (lossEvt) loss_d = sat_inc8(loss_q);

    if (restart_i) begin
      state_d = S_RESET_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_HOLD: if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (lockSync_q) begin
            state_d = S_STABLE;
          end else if (timer_q == TO_LAST) begin
            if (retry_q == MAX_R) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_HOLD;
              retry_d = retry_q + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!lockSync_q) state_d = S_WAIT_LOCK;
          else if (timer_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lockSync_q) begin
            state_d = S_RESET_HOLD;
            retry_d = '0;
          end
        end
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_RESET_HOLD;
      endcase
    end

    // Timer restarts on every state entry; it parks in RUN once the release delay is met.
    if (restart_i || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == S_FAIL) || ((state_q == S_RUN) && (timer_q == RSTN_LAST))) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 32'd1;
    end

    mmcmRst_d  = (state_d == S_RESET_HOLD) || (state_d == S_FAIL);
    pllReady_d = (state_d == S_RUN);
    fail_d     = (state_d == S_FAIL);
    sysRstn_d  = (state_d == S_RUN) && (state_q == S_RUN) && (timer_q == RSTN_LAST);
  end

  always_ff @(posedge sysClk_i or negedge RESETn_i) begin
    if (!RESETn_i) begin
      lockMeta_q <= 1'b0;
      lockSync_q <= 1'b0;
      state_q    <= S_RESET_HOLD;
      timer_q    <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      mmcmRst_q  <= 1'b1;
      pllReady_q <= 1'b0;
      sysRstn_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      lockMeta_q <= mmcmLocked_i;
      lockSync_q <= lockMeta_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      mmcmRst_q  <= mmcmRst_d;
      pllReady_q <= pllReady_d;
      sysRstn_q  <= sysRstn_d;
      fail_q     <= fail_d;
    end
  end

  assign mmcmRst_o     = mmcmRst_q;
  assign pllReady_o    = pllReady_q;
  assign sysRstn_o     = sysRstn_q;
  assign fail_o        = fail_q;
  assign retryCnt_o    = retry_q;
  assign lockLossCnt_o = loss_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mmcm_lock_sequencer.sv
// Scoreboard bench for mmcm_lock_sequencer: each scenario queues its expected
// observations as it drives stimulus, then compares them against the sampled outputs.
module tb_mmcm_lock_sequencer;

  logic       sysClk_i = 1'b0;
  logic       RESETn_i;
  logic       mmcmLocked_i;
  logic       restart_i;
  logic       mmcmRst_o, pllReady_o, sysRstn_o, fail_o;
  logic [3:0] retryCnt_o;
  logic [7:0] lockLossCnt_o;
  logic [2:0] state_o;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          vectors = 0;
  int          miscompares = 0;

  mmcm_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRY(2), .RSTN_DELAY(3)
  ) dut (
    .sysClk_i(sysClk_i), .RESETn_i(RESETn_i), .mmcmLocked_i(mmcmLocked_i),
    .restart_i(restart_i), .mmcmRst_o(mmcmRst_o), .pllReady_o(pllReady_o),
    .sysRstn_o(sysRstn_o), .fail_o(fail_o), .retryCnt_o(retryCnt_o),
    .lockLossCnt_o(lockLossCnt_o), .state_o(state_o)
  );

  always #5 sysClk_i = ~sysClk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge sysClk_i);
    #1;
  endtask

  task automatic expect_v(input string nm, input logic [31:0] v);
    sb.push_back('{name: nm, val: v});
  endtask

  task automatic push_reset_values(input string tag);
    expect_v({tag, "_mmcmRst"}, 1);
    expect_v({tag, "_pllReady"}, 0);
    expect_v({tag, "_sysRstn"}, 0);
    expect_v({tag, "_fail"}, 0);
    expect_v({tag, "_retry"}, 0);
    expect_v({tag, "_lossCnt"}, 0);
    expect_v({tag, "_state"}, 0);
  endtask

  task automatic sample_all();
    obs.push_back(32'(mmcmRst_o));
    obs.push_back(32'(pllReady_o));
    obs.push_back(32'(sysRstn_o));
    obs.push_back(32'(fail_o));
    obs.push_back(32'(retryCnt_o));
    obs.push_back(32'(lockLossCnt_o));
    obs.push_back(32'(state_o));
  endtask

  task automatic do_reset();
    RESETn_i  = 1'b0;
    restart_i = 1'b0;
    step();
    step();
    RESETn_i = 1'b1;
  endtask

  task automatic wait_rst_fall();
    for (int i = 0; i < 100 && mmcmRst_o === 1'b1; i++) step();
  endtask

  task automatic bring_up();
    mmcmLocked_i = 1'b1;
    for (int i = 0; i < 200 && sysRstn_o !== 1'b1; i++) step();
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    RESETn_i = 1'b1;
    mmcmLocked_i = 1'b0;
    restart_i = 1'b0;
    #2 RESETn_i = 1'b0;
    #1;
    push_reset_values("rst");
    sample_all();
    step();
    expect_v("rst_held_state", 0);
    expect_v("rst_held_mmcmRst", 1);
    obs.push_back(32'(state_o));
    obs.push_back(32'(mmcmRst_o));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  task automatic test_nominal();
    exp_t e;
    logic [31:0] o;
    int n;
    mmcmLocked_i = 1'b0;
    do_reset();
    expect_v("nom_rst_len", 4);
    n = 0;
    while (mmcmRst_o === 1'b1 && n < 100) begin step(); n++; end
    obs.push_back(32'(n));
    expect_v("nom_state_wait", 1);
    obs.push_back(32'(state_o));
    repeat (5) step();
    mmcmLocked_i = 1'b1;
    expect_v("nom_lock_to_ready", 11);
    n = 0;
    while (pllReady_o !== 1'b1 && n < 100) begin step(); n++; end
    obs.push_back(32'(n));
    expect_v("nom_ready_to_rstn", 3);
    n = 0;
    while (sysRstn_o !== 1'b1 && n < 100) begin step(); n++; end
    obs.push_back(32'(n));
    expect_v("nom_retry", 0);
    expect_v("nom_state_run", 3);
    expect_v("nom_mmcmRst", 0);
    obs.push_back(32'(retryCnt_o));
    obs.push_back(32'(state_o));
    obs.push_back(32'(mmcmRst_o));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [31:0] o;
    int n;
    mmcmLocked_i = 1'b0;
    do_reset();
    wait_rst_fall();
    for (int t = 1; t <= 2; t++) begin
      expect_v($sformatf("to_wait_len_%0d", t), 20);
      n = 0;
      while (mmcmRst_o === 1'b0 && n < 100) begin step(); n++; end
      obs.push_back(32'(n));
      expect_v($sformatf("to_retry_%0d", t), 32'(t));
      obs.push_back(32'(retryCnt_o));
      expect_v($sformatf("to_pulse_len_%0d", t), 4);
      n = 0;
      while (mmcmRst_o === 1'b1 && n < 100) begin step(); n++; end
      obs.push_back(32'(n));
    end
    expect_v("to_wait_len_3", 20);
    n = 0;
    while (fail_o !== 1'b1 && n < 100) begin step(); n++; end
    obs.push_back(32'(n));
    expect_v("to_fail_state", 4);
    expect_v("to_fail_mmcmRst", 1);
    expect_v("to_fail_retry", 2);
    expect_v("to_fail_sysRstn", 0);
    obs.push_back(32'(state_o));
    obs.push_back(32'(mmcmRst_o));
    obs.push_back(32'(retryCnt_o));
    obs.push_back(32'(sysRstn_o));
    repeat (30) step();
    expect_v("to_fail_parked", 1);
    expect_v("to_fail_parked_state", 4);
    obs.push_back(32'(fail_o));
    obs.push_back(32'(state_o));
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    expect_v("to_restart_state", 0);
    expect_v("to_restart_retry", 0);
    expect_v("to_restart_fail", 0);
    expect_v("to_restart_mmcmRst", 1);
    obs.push_back(32'(state_o));
    obs.push_back(32'(retryCnt_o));
    obs.push_back(32'(fail_o));
    obs.push_back(32'(mmcmRst_o));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  task automatic test_glitch();
    exp_t e;
    logic [31:0] o;
    logic [2:0] prev;
    logic [31:0] trace[$];
    int n;
    mmcmLocked_i = 1'b0;
    do_reset();
    wait_rst_fall();
    expect_v("gl_changes", 4);
    expect_v("gl_change0_stable", 2);
    expect_v("gl_change1_wait", 1);
    expect_v("gl_change2_stable", 2);
    expect_v("gl_change3_run", 3);
    expect_v("gl_relock_to_ready", 11);
    expect_v("gl_retry", 0);
    prev = state_o;
    mmcmLocked_i = 1'b1;
    repeat (5) begin
      step();
      if (state_o !== prev) begin trace.push_back(32'(state_o)); prev = state_o; end
    end
    mmcmLocked_i = 1'b0;
    step();
    if (state_o !== prev) begin trace.push_back(32'(state_o)); prev = state_o; end
    mmcmLocked_i = 1'b1;
    n = 0;
    while (pllReady_o !== 1'b1 && n < 100) begin
      step();
      n++;
      if (state_o !== prev) begin trace.push_back(32'(state_o)); prev = state_o; end
    end
    obs.push_back(32'(trace.size()));
    for (int i = 0; i < 4; i++) obs.push_back((i < trace.size()) ? trace[i] : '1);
    obs.push_back(32'(n));
    obs.push_back(32'(retryCnt_o));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  task automatic test_lock_loss();
    exp_t e;
    logic [31:0] o;
    mmcmLocked_i = 1'b0;
    do_reset();
    bring_up();
    expect_v("ll_rstn_before", 1);
    obs.push_back(32'(sysRstn_o));
    mmcmLocked_i = 1'b0;
    step();
    mmcmLocked_i = 1'b1;
    step();
    expect_v("ll_ready_at_2", 1);
    obs.push_back(32'(pllReady_o));
    step();
    expect_v("ll_pllReady", 0);
    expect_v("ll_sysRstn", 0);
    expect_v("ll_mmcmRst", 1);
    expect_v("ll_lossCnt", 1);
    expect_v("ll_retry", 0);
    expect_v("ll_state", 0);
    obs.push_back(32'(pllReady_o));
    obs.push_back(32'(sysRstn_o));
    obs.push_back(32'(mmcmRst_o));
    obs.push_back(32'(lockLossCnt_o));
    obs.push_back(32'(retryCnt_o));
    obs.push_back(32'(state_o));
    for (int i = 2; i <= 257; i++) begin
      bring_up();
      mmcmLocked_i = 1'b0;
      step();
      mmcmLocked_i = 1'b1;
      step();
      step();
      if (i == 128) begin
        expect_v("ll_lossCnt_128", 128);
        obs.push_back(32'(lockLossCnt_o));
      end
      if (i == 256) begin
        expect_v("ll_lossCnt_256", 255);
        obs.push_back(32'(lockLossCnt_o));
      end
    end
    expect_v("ll_lossCnt_257", 255);
    obs.push_back(32'(lockLossCnt_o));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    logic [31:0] o;
    mmcmLocked_i = 1'b0;
    do_reset();
    bring_up();
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    expect_v("sim_restart_run_state", 0);
    expect_v("sim_restart_run_loss", 0);
    obs.push_back(32'(state_o));
    obs.push_back(32'(lockLossCnt_o));
    bring_up();
    mmcmLocked_i = 1'b0;
    step();
    mmcmLocked_i = 1'b1;
    step();
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    expect_v("sim_both_state", 0);
    expect_v("sim_both_loss", 1);
    expect_v("sim_both_retry", 0);
    expect_v("sim_both_pllReady", 0);
    obs.push_back(32'(state_o));
    obs.push_back(32'(lockLossCnt_o));
    obs.push_back(32'(retryCnt_o));
    obs.push_back(32'(pllReady_o));
    mmcmLocked_i = 1'b0;
    wait_rst_fall();
    repeat (17) step();
    mmcmLocked_i = 1'b1;
    step();
    step();
    expect_v("sim_pre_timeout_state", 1);
    obs.push_back(32'(state_o));
    step();
    expect_v("sim_timeout_lock_state", 2);
    expect_v("sim_timeout_lock_retry", 0);
    obs.push_back(32'(state_o));
    obs.push_back(32'(retryCnt_o));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] o;
    mmcmLocked_i = 1'b0;
    do_reset();
    wait_rst_fall();
    mmcmLocked_i = 1'b1;
    repeat (5) step();
    expect_v("mid_state_stable", 2);
    obs.push_back(32'(state_o));
    #2 RESETn_i = 1'b0;
    #1;
    push_reset_values("mid_stable");
    sample_all();
    step();
    RESETn_i = 1'b1;
    bring_up();
    mmcmLocked_i = 1'b0;
    step();
    mmcmLocked_i = 1'b1;
    step();
    step();
    bring_up();
    expect_v("mid_run_loss", 1);
    expect_v("mid_run_sysRstn", 1);
    obs.push_back(32'(lockLossCnt_o));
    obs.push_back(32'(sysRstn_o));
    #3 RESETn_i = 1'b0;
    #1;
    push_reset_values("mid_run");
    sample_all();
    step();
    RESETn_i = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (obs.size() > 0) o = obs.pop_front(); else o = '1;
      vectors++;
      if (o !== e.val) begin
        miscompares++;
        $display("FAIL %s: observed %0d, expected %0d", e.name, o, e.val);
      end
    end
    obs.delete();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_glitch();
    test_lock_loss();
    test_simultaneous();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
